// File: rtl/mux_nx1_scan.sv
// Purpose : registered NCH-to-1 channel mux with manual, auto-scan (up/down) and hold selection.
// Latency : one clk_2 edge from din/sel/mode to dout/cur_ch/ch_change/sel_err.
// Backpressure: none; inputs are sampled on every rising edge of clk_2.
//
// Ports:
//   clk_2     - system clock, all state on rising edge
//   reset_n   - asynchronous active-low reset
//   din       - packed channels, channel k = din[k*WIDTH +: WIDTH]
//   mode      - 00 MANUAL, 01 SCAN_UP, 10 HOLD, 11 SCAN_DOWN
//   sel       - channel request, only honoured in MANUAL
//   dout      - registered data of the selected channel
//   cur_ch    - registered index of the selected channel
//   ch_change - one-cycle pulse when cur_ch changed on the last edge
//   sel_err   - high while MANUAL requests a channel >= NCH
module mux_nx1_scan #(
    parameter int WIDTH = 1,
    parameter int NCH   = 2,
    parameter int DWELL = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk_2,
    input  logic                   reset_n,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [1:0]             mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       dout,
    output logic [SELW-1:0]        cur_ch,
    output logic                   ch_change,
    output logic                   sel_err
);

    localparam logic [1:0] MODE_MANUAL    = 2'b00;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
    localparam logic [1:0] MODE_HOLD      = 2'b10;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b11;

    localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(NCH - 1);
    // One extra bit so NCH itself is representable when NCH is a power of two.
    localparam logic [SELW:0]   NCH_EXT  = (SELW + 1)'(NCH);

    logic [WIDTH-1:0] dout_q,      dout_d;
    logic [SELW-1:0]  cur_ch_q,    nxt_ch;
    logic             ch_change_q, ch_change_d;
    logic             sel_err_q,   sel_err_d;
    logic [CNTW-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [1:0]       prev_mode_q;

    logic             mode_chg;
    logic [CNTW-1:0]  cnt_eff;
    logic             dwell_last;
    logic             sel_ok;
    logic [SELW-1:0]  ch_inc;
    logic [SELW-1:0]  ch_dec;
    logic [WIDTH-1:0] sel_dat;

    // Channel stepping and dwell counting.
    always_comb begin
        mode_chg    = (mode != prev_mode_q);
        // The edge on which the mode changes is dwell count 0 of the new mode,
        // so the first scan step lands DWELL edges after entry (counting the
        // entry edge itself).
        cnt_eff     = mode_chg ? '0 : dwell_cnt_q;
        dwell_last  = (cnt_eff == CNT_LAST);
        sel_ok      = ({1'b0, sel} < NCH_EXT);
        // Wrap at both ends; with NCH=1 both collapse to channel 0.
        ch_inc      = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + 1'b1;
        ch_dec      = (cur_ch_q == '0) ? CH_LAST : cur_ch_q - 1'b1;

        nxt_ch      = cur_ch_q;
        dwell_cnt_d = dwell_cnt_q;
        sel_err_d   = 1'b0;

        case (mode)
            MODE_MANUAL: begin
                dwell_cnt_d = '0;
                if (sel_ok) begin
                    nxt_ch = sel;
                end else begin
                    sel_err_d = 1'b1;
                end
            end
            MODE_SCAN_UP: begin
                if (dwell_last) begin
                    dwell_cnt_d = '0;
                    nxt_ch      = ch_inc;
                end else begin
                    dwell_cnt_d = cnt_eff + 1'b1;
                end
            end
            MODE_SCAN_DOWN: begin
                if (dwell_last) begin
                    dwell_cnt_d = '0;
                    nxt_ch      = ch_dec;
                end else begin
                    dwell_cnt_d = cnt_eff + 1'b1;
                end
            end
            default: begin
                // HOLD: counter frozen, but still cleared on the entry edge.
                dwell_cnt_d = cnt_eff;
            end
        endcase
    end

    // Data path: pick the slice for the channel being registered this edge.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (nxt_ch == SELW'(k)) begin
                sel_dat = din[k*WIDTH +: WIDTH];
            end
        end
        dout_d      = (mode == MODE_HOLD) ? dout_q : sel_dat;
        ch_change_d = (nxt_ch != cur_ch_q);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            dout_q      <= '0;
            cur_ch_q    <= '0;
            ch_change_q <= 1'b0;
            sel_err_q   <= 1'b0;
            dwell_cnt_q <= '0;
            prev_mode_q <= MODE_MANUAL;
        end else begin
            dout_q      <= dout_d;
            cur_ch_q    <= nxt_ch;
            ch_change_q <= ch_change_d;
            sel_err_q   <= sel_err_d;
            dwell_cnt_q <= dwell_cnt_d;
            prev_mode_q <= mode;
        end
    end

    assign dout      = dout_q;
    assign cur_ch    = cur_ch_q;
    assign ch_change = ch_change_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Purpose : self-checking bench for mux_nx1_scan (WIDTH=4, NCH=3, DWELL=2).
// Latency : reference model updates on the same edge as the DUT, compared on the falling edge.
// Backpressure: n/a.
module tb_mux_nx1_scan;

    localparam int WIDTH = 4;
    localparam int NCH   = 3;
    localparam int DWELL = 2;
    localparam int SELW  = 2;

    logic                 clk_2;
    logic                 reset_n;
    logic [NCH*WIDTH-1:0] din;
    logic [1:0]           mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     dout;
    logic [SELW-1:0]      cur_ch;
    logic                 ch_change;
    logic                 sel_err;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    mux_nx1_scan #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL)) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .din       (din),
        .mode      (mode),
        .sel       (sel),
        .dout      (dout),
        .cur_ch    (cur_ch),
        .ch_change (ch_change),
        .sel_err   (sel_err)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: counts how many consecutive edges the current mode has
    // been active; a scan step happens whenever that run length is a multiple
    // of DWELL. Channels wrap with modular arithmetic.
    int             m_ch;
    int             m_run;
    int             m_nx;
    logic [WIDTH-1:0] m_dout;
    bit             m_chg;
    bit             m_err;
    logic [1:0]     m_prev;

    always @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            m_ch   = 0;
            m_run  = 0;
            m_dout = '0;
            m_chg  = 0;
            m_err  = 0;
            m_prev = 2'b00;
        end else begin
            m_nx  = m_ch;
            m_run = (mode == m_prev) ? m_run + 1 : 1;
            m_err = 0;
            case (mode)
                2'b00: if (int'(sel) < NCH) m_nx = int'(sel); else m_err = 1;
                2'b01: if (m_run % DWELL == 0) m_nx = (m_ch + 1) % NCH;
                2'b11: if (m_run % DWELL == 0) m_nx = (m_ch + NCH - 1) % NCH;
                default: ;
            endcase
            m_chg = (m_nx != m_ch);
            if (mode != 2'b10) m_dout = din[m_nx*WIDTH +: WIDTH];
            m_ch   = m_nx;
            m_prev = mode;
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk_2) begin
        if (cmp_en) begin
            chk("mdl_dout",      int'(dout),      int'(m_dout));
            chk("mdl_cur_ch",    int'(cur_ch),    m_ch);
            chk("mdl_ch_change", int'(ch_change), int'(m_chg));
            chk("mdl_sel_err",   int'(sel_err),   int'(m_err));
        end
    end

    int exp_ch  [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    int exp_dat [8] = '{'hA, 'hA, 'hB, 'hB, 'hC, 'hC, 'hA, 'hA};
    int exp_chg [8] = '{0, 0, 1, 0, 1, 0, 1, 0};

    initial begin
        reset_n = 1'b0;
        din     = {4'hC, 4'hB, 4'hA};
        mode    = 2'b00;
        sel     = '0;
        cmp_en  = 1;

        // Reset values.
        repeat (2) @(negedge clk_2);
        chk("rst_dout",      int'(dout),      0);
        chk("rst_cur_ch",    int'(cur_ch),    0);
        chk("rst_ch_change", int'(ch_change), 0);
        chk("rst_sel_err",   int'(sel_err),   0);

        // 1: MANUAL sel=2.
        reset_n = 1'b1;
        sel     = 2'd2;
        @(negedge clk_2);
        chk("t1_dout",      int'(dout),      'hC);
        chk("t1_cur_ch",    int'(cur_ch),    2);
        chk("t1_ch_change", int'(ch_change), 1);
        chk("t1_sel_err",   int'(sel_err),   0);
        @(negedge clk_2);
        chk("t1_pulse_end", int'(ch_change), 0);

        // 2: out-of-range request holds the channel.
        sel = 2'd3;
        @(negedge clk_2);
        chk("t2_cur_ch",    int'(cur_ch),    2);
        chk("t2_dout",      int'(dout),      'hC);
        chk("t2_sel_err",   int'(sel_err),   1);
        chk("t2_ch_change", int'(ch_change), 0);

        // 3: SCAN_UP from channel 0 (state at entry plus the following edges).
        sel = 2'd0;
        @(negedge clk_2);
        mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk_2);
            chk("t3_cur_ch", int'(cur_ch), exp_ch[i]);
            chk("t3_dout",   int'(dout),   exp_dat[i]);
            chk("t3_sel_err", int'(sel_err), 0);
            if (i > 0) chk("t3_ch_change", int'(ch_change), exp_chg[i]);
        end

        // 4: SCAN_DOWN from channel 0 wraps to NCH-1 after DWELL edges.
        mode = 2'b11;
        @(negedge clk_2);
        chk("t4_cur_ch_e1", int'(cur_ch), 0);
        @(negedge clk_2);
        chk("t4_cur_ch_e2", int'(cur_ch),    2);
        chk("t4_dout",      int'(dout),      'hC);
        chk("t4_ch_change", int'(ch_change), 1);

        // 5: HOLD at channel 1 ignores din changes; resuming scan re-counts.
        mode = 2'b00;
        sel  = 2'd1;
        @(negedge clk_2);
        chk("t5_pre_dout", int'(dout), 'hB);
        mode = 2'b10;
        din  = {4'hC, 4'h5, 4'hA};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2);
            chk("t5_hold_dout",      int'(dout),      'hB);
            chk("t5_hold_cur_ch",    int'(cur_ch),    1);
            chk("t5_hold_ch_change", int'(ch_change), 0);
        end
        mode = 2'b01;
        @(negedge clk_2);
        chk("t5_resume_e1", int'(cur_ch), 1);
        @(negedge clk_2);
        chk("t5_resume_e2",      int'(cur_ch),    2);
        chk("t5_resume_dout",    int'(dout),      'hC);
        chk("t5_resume_ch_chg",  int'(ch_change), 1);

        // 6: asynchronous reset mid-scan, between edges.
        repeat (2) @(negedge clk_2);
        @(posedge clk_2);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_dout",      int'(dout),      0);
        chk("t6_cur_ch",    int'(cur_ch),    0);
        chk("t6_ch_change", int'(ch_change), 0);
        chk("t6_sel_err",   int'(sel_err),   0);
        @(negedge clk_2);
        reset_n = 1'b1;

        // Randomized phase: sticky modes, random selects, data and resets.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_2);
            if (reset_n == 1'b0) begin
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) din = 12'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset_n = 1'b0;
            end
        end

        @(negedge clk_2);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
